// File: rtl/ysyx_22040931_mul_div_pkg.sv
// ysyx_22040931_mul_div_pkg: shared ALU/extension encodings, FSM states and op-class helpers
package ysyx_22040931_mul_div_pkg;
  localparam int XLEN_DEF = 64;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;
  localparam logic [4:0] OP_DIVUW  = 5'd18;
  localparam logic [4:0] OP_REMW   = 5'd19;
  localparam logic [4:0] OP_REMUW  = 5'd20;
  localparam logic [2:0] EX_SHORT  = 3'd1;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
  function automatic logic is_word(input logic [4:0] op, input logic [2:0] ex);
    return ex == EX_SHORT || op inside {OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction
  function automatic logic op_mul(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction
  function automatic logic op_div(input logic [4:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_DIVUW};
  endfunction
  function automatic logic op_rem(input logic [4:0] op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction
  function automatic logic sgn1(input logic [4:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_REMW};
  endfunction
  function automatic logic sgn2(input logic [4:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM, OP_REMW};
  endfunction
endpackage

// File: rtl/ysyx_22040931_mul_div_if.sv
// ysyx_22040931_mul_div_if: decode-side request and result handshake of the mul/div unit
interface ysyx_22040931_mul_div_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      aluop;
  logic [2:0]      exop;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  modport master (output in_valid, aluop, exop, src1, src2, flush, out_ready,
                  input in_ready, out_valid, result);
  modport slave (input in_valid, aluop, exop, src1, src2, flush, out_ready,
                 output in_ready, out_valid, result);
endinterface

// File: rtl/ysyx_22040931_div_step.sv
// ysyx_22040931_div_step: one restoring-division step on unsigned magnitudes
module ysyx_22040931_div_step #(parameter int XLEN = 64) (
  input  logic [XLEN-1:0] rem,
  input  logic            bit_in,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_next,
  output logic            q
);
  logic [XLEN:0] t, diff;
  // rem < dvs keeps t - dvs below 2^XLEN, so the top bit is a pure borrow flag
  assign t        = {rem, bit_in};
  assign diff     = t - {1'b0, dvs};
  assign q        = ~diff[XLEN];
  assign rem_next = q ? diff[XLEN-1:0] : t[XLEN-1:0];
endmodule

// File: rtl/ysyx_22040931_mul_div.sv
// ysyx_22040931_mul_div: iterative RV64 M-extension multiplier/divider with word mode
module ysyx_22040931_mul_div
  import ysyx_22040931_mul_div_pkg::*;
#(parameter int XLEN = XLEN_DEF) (
  input logic                  clk,
  input logic                  rst_n,
  ysyx_22040931_mul_div_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, last;
  logic [4:0] op;
  logic word, neg1, neg2;
  logic [XLEN-1:0] mq, result;
  logic [2*XLEN-1:0] mcand, acc;
  logic accept, word_in, s1_in, s2_in, neg1_in, neg2_in, sup, div0, ovf, special;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_neg, spec_res;
  logic [2*XLEN-1:0] prod_n, prod_s;
  logic [XLEN-1:0] rem_n, quo_n, quo_s, rem_s, fin_res;
  logic qb;
  function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction
  assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;
  assign bus.in_ready  = state == S_IDLE;
  assign bus.out_valid = state == S_DONE;
  assign bus.result    = result;
  always_comb begin
    word_in  = is_word(bus.aluop, bus.exop);
    s1_in    = sgn1(bus.aluop);
    s2_in    = sgn2(bus.aluop);
    ext1     = word_in ? {{(XLEN-32){s1_in & bus.src1[31]}}, bus.src1[31:0]} : bus.src1;
    ext2     = word_in ? {{(XLEN-32){s2_in & bus.src2[31]}}, bus.src2[31:0]} : bus.src2;
    neg1_in  = s1_in & ext1[XLEN-1];
    neg2_in  = s2_in & ext2[XLEN-1];
    mag1     = neg1_in ? -ext1 : ext1;
    mag2     = neg2_in ? -ext2 : ext2;
    min_neg  = word_in ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    sup      = op_mul(bus.aluop) | op_div(bus.aluop) | op_rem(bus.aluop);
    div0     = (op_div(bus.aluop) | op_rem(bus.aluop)) && ext2 == '0;
    ovf      = s1_in && s2_in && !op_mul(bus.aluop) && ext1 == min_neg && ext2 == {XLEN{1'b1}};
    special  = !sup || div0 || ovf;
    spec_res = !sup ? '0 : wfix(div0 ? (op_div(bus.aluop) ? {XLEN{1'b1}} : ext1)
                                     : (op_div(bus.aluop) ? ext1 : '0), word_in);
  end
  ysyx_22040931_div_step #(.XLEN(XLEN)) u_step (
    .rem(acc[XLEN-1:0]), .bit_in(mq[XLEN-1]), .dvs(mcand[XLEN-1:0]),
    .rem_next(rem_n), .q(qb)
  );
  // the final result is formed from the last step's next values so DONE follows BUSY cycle N directly
  always_comb begin
    prod_n  = acc + (mq[0] ? mcand : '0);
    quo_n   = {mq[XLEN-2:0], qb};
    prod_s  = (neg1 ^ neg2) ? -prod_n : prod_n;
    quo_s   = (neg1 ^ neg2) ? -quo_n : quo_n;
    rem_s   = neg1 ? -rem_n : rem_n;
    fin_res = op_mul(op) ? (op == OP_MUL ? wfix(prod_n[XLEN-1:0], word) : XLEN'(prod_s >> XLEN))
                         : wfix(op_div(op) ? quo_s : rem_s, word);
    last    = word ? CW'(31) : CW'(XLEN-1);
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = special ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt == last) state_n = S_DONE;
      S_DONE:  if (bus.out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (bus.flush) state_n = S_IDLE;
  end
  always_ff @(posedge clk)
    state <= !rst_n ? S_IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else if (accept) begin
      op    <= bus.aluop;
      word  <= word_in;
      neg1  <= neg1_in;
      neg2  <= neg2_in;
      acc   <= '0;
      cnt   <= '0;
      mcand <= {{XLEN{1'b0}}, op_mul(bus.aluop) ? mag1 : mag2};
      mq    <= op_mul(bus.aluop) ? mag2 : (word_in ? mag1 << 32 : mag1);
      if (special) result <= spec_res;
    end else if (state == S_BUSY) begin
      cnt <= cnt + 1'b1;
      if (op_mul(op)) begin
        acc   <= prod_n;
        mcand <= mcand << 1;
        mq    <= mq >> 1;
      end else begin
        acc <= {{XLEN{1'b0}}, rem_n};
        mq  <= quo_n;
      end
      if (cnt == last) result <= fin_res;
    end
  end
endmodule

// File: tb/tb_ysyx_22040931_mul_div.sv
// tb_ysyx_22040931_mul_div: directed vectors for the mul/div unit with assertion checks
module tb_ysyx_22040931_mul_div;
  import ysyx_22040931_mul_div_pkg::*;
  logic clk, rst_n;
  int passed = 0, total = 0, fails = 0;
  ysyx_22040931_mul_div_if #(.XLEN(64)) bus ();
  ysyx_22040931_mul_div #(.XLEN(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed += 1;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [4:0] op, input logic [2:0] ex,
                     input logic [63:0] a, input logic [63:0] b, input int lat_exp,
                     input logic [63:0] exp, input int hold);
    int lat;
    @(negedge clk);
    bus.in_valid = 1; bus.aluop = op; bus.exop = ex; bus.src1 = a; bus.src2 = b;
    @(posedge clk); #1;
    bus.in_valid = 0; bus.aluop = 5'd31; bus.exop = 3'd0; bus.src1 = ~a; bus.src2 = ~b;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(lat_exp));
    check({tag, ".res"}, bus.result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_v"}, {63'b0, bus.out_valid}, 64'd1);
      check({tag, ".hold_r"}, bus.result, exp);
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    check({tag, ".rel"}, {62'b0, bus.in_ready, bus.out_valid}, 64'b10);
  endtask
  initial begin
    logic seen;
    rst_n = 0;
    bus.in_valid = 0; bus.aluop = 0; bus.exop = 0; bus.src1 = 0; bus.src2 = 0;
    bus.flush = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("rst.out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("rst.result", bus.result, 64'd0);
    @(negedge clk) rst_n = 1;
    run("mul", OP_MUL, 3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 65, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    run("mulhu", OP_MULHU, 3'd0, '1, '1, 65, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run("mulh", OP_MULH, 3'd0, '1, '1, 65, 64'd0, 0);
    run("mulhsu", OP_MULHSU, 3'd0, '1, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("divu", OP_DIVU, 3'd0, 64'd100, 64'd7, 65, 64'd14, 0);
    run("div_neg", OP_DIV, 3'd0, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run("rem_neg", OP_REM, 3'd0, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("div0", OP_DIV, 3'd0, 64'd7, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("rem0", OP_REM, 3'd0, 64'd7, 64'd0, 1, 64'd7, 0);
    run("div_ovf", OP_DIV, 3'd0, 64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000, 0);
    run("rem_ovf", OP_REM, 3'd0, 64'h8000_0000_0000_0000, '1, 1, 64'd0, 0);
    run("divw_ovf", OP_DIV, EX_SHORT, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, 0);
    run("remuw", OP_REMUW, 3'd0, 64'h1_0000_0007, 64'd3, 33, 64'd1, 0);
    run("mulw", OP_MUL, EX_SHORT, 64'h7FFF_FFFF, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run("remw", OP_REMW, 3'd0, 64'hFFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("divuw", OP_DIVUW, 3'd0, 64'hFFFF_FFFF, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("unsup", 5'd0, 3'd0, 64'd5, 64'd6, 1, 64'd0, 0);
    run("hold", OP_MUL, 3'd0, 64'd5, 64'd6, 65, 64'd30, 10);
    // flush beats a simultaneous offer in IDLE
    @(negedge clk);
    bus.in_valid = 1; bus.flush = 1; bus.aluop = OP_DIV; bus.src1 = 64'd7; bus.src2 = 64'd0;
    @(posedge clk); #1;
    bus.in_valid = 0; bus.flush = 0;
    check("flush.noacc", {62'b0, bus.in_ready, bus.out_valid}, 64'b10);
    // flush in BUSY cycle 20
    @(negedge clk);
    bus.in_valid = 1; bus.aluop = OP_DIVU; bus.exop = 3'd0; bus.src1 = 64'd1000; bus.src2 = 64'd3;
    @(posedge clk); #1;
    bus.in_valid = 0;
    repeat (19) @(posedge clk);
    #1 bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    check("flush.idle", {62'b0, bus.in_ready, bus.out_valid}, 64'b10);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("flush.never_valid", {63'b0, seen}, 64'd0);
    // reset in BUSY
    @(negedge clk);
    bus.in_valid = 1; bus.aluop = OP_MUL; bus.src1 = 64'd7; bus.src2 = 64'd9;
    @(posedge clk); #1;
    bus.in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("rst_busy.in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("rst_busy.out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("rst_busy.result", bus.result, 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("rst_busy.never_valid", {63'b0, seen}, 64'd0);
    run("after_rst", OP_DIVU, 3'd0, 64'd100, 64'd7, 65, 64'd14, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ysyx_22040931_mul_div.md
YSYX_22040931_MUL_DIV -- requirements
Module: ysyx_22040931_mul_div

Interface
REQ-001 SHALL have parameter: XLEN, 64, datapath width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operation offered by the decode stage.
REQ-005 SHALL have port: in_ready  output  1  unit can accept an operation.
REQ-006 SHALL have port: aluop  input  5  operation code, R-type ALU encoding from defines.v.
REQ-007 SHALL have port: exop  input  3  extension code; Short selects 32-bit word mode.
REQ-008 SHALL have port: src1 / src2  input  XLEN  operands (rs1, rs2).
REQ-009 SHALL have port: flush  input  1  abort the current operation.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port: result  output  XLEN  final value.

Function
REQ-013 SHALL execute MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, DIVUW, REMW and REMUW, plus MUL/DIV with exop=Short (MULW, DIVW).
REQ-014 SHALL treat an operation as word mode when exop==Short or aluop is one of {DIVUW, REMW, REMUW}.
- Word mode uses the low 32 operand bits, sign- or zero-extended per signedness.
- Word mode returns result[31:0] sign-extended to 64 bits.
REQ-015 SHALL accept an operation only when in_valid && in_ready && !flush; operands and op are latched on that edge.
REQ-016 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE, with in_ready=1 only in IDLE.
REQ-017 SHALL iterate N cycles in BUSY (N=64, or 32 in word mode), one bit per cycle:
- MUL* uses shift-add on unsigned magnitudes;
- DIV*/REM* uses a restoring shift-subtract on unsigned magnitudes.
REQ-018 SHALL apply signs after iteration:
- MULH: both operands signed.
- MULHSU: src1 signed, src2 unsigned.
- Quotient sign = sign1 XOR sign2.
- Remainder sign = dividend sign.
REQ-019 SHALL return low XLEN bits for MUL and high XLEN bits for MULH, MULHSU and MULHU.
REQ-020 SHALL assert out_valid exactly N+1 cycles after the accepting edge for normal ops.
REQ-021 SHALL handle divide by zero by going IDLE -> DONE directly (out_valid 1 cycle after accept): quotient = all ones, remainder = dividend (in the effective width).
REQ-022 SHALL handle signed overflow (most-negative / -1) the same way: quotient = dividend, remainder = 0.
REQ-023 SHALL accept an unsupported aluop, go directly to DONE and return result 0.
REQ-024 SHALL hold result and out_valid stable in DONE until out_ready=1, then return to IDLE on that edge; a new op is not accepted in that same cycle.
REQ-025 SHALL on flush=1 at any state return to IDLE on the next edge with out_valid=0 and the result discarded; flush wins over a simultaneous in_valid or out_ready.

Reset
REQ-026 SHALL, while rst_n=0 at a clk edge, enter IDLE with out_valid=0, in_ready=1 and result=0, and clear the iteration counter.
REQ-027 SHALL abort an in-flight operation on reset mid-BUSY/DONE and never deliver its result.

Structure
REQ-028 SHALL take aluop/exop encodings (MUL..REMUW, Short, Arith) only from the shared defines.v; no local numeric literals.
REQ-029 SHALL place FSM state encodings and XLEN default in defines.v.
REQ-030 SHALL use one sub-module, ysyx_22040931_div_step (combinational single restoring-division step: partial remainder, divisor -> next remainder, quotient bit).

Verification
REQ-031 SHALL cover MUL src1=3, src2=0xFFFF_FFFF_FFFF_FFFB -> result 0xFFFF_FFFF_FFFF_FFF1, out_valid at cycle 65 after accept.
REQ-032 SHALL cover MULHU with both operands 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands -> 0.
REQ-033 SHALL cover divide by zero: DIV 7/0 -> 0xFFFF_FFFF_FFFF_FFFF; REM 7%0 -> 7; each with out_valid 1 cycle after accept.
REQ-034 SHALL cover overflow:
- DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
- DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
REQ-035 SHALL cover word mode: REMUW src1=0x1_0000_0007, src2=3 -> 1, out_valid at cycle 33.
REQ-036 SHALL cover control timing:
- out_ready held 0 for 10 cycles in DONE -> result/out_valid stable throughout.
- flush at BUSY cycle 20 -> out_valid never rises, in_ready=1 next cycle.
- rst_n=0 mid-BUSY -> IDLE outputs per REQ-026.
